// File: rtl/dino_floor_controller.sv
// dino_floor_controller: per-tick dinosaur jump/fall physics, floor landing and cactus collision.
// Optional macro DINO_JUMP_BUFFER_EN keeps a mid-air jump request and relaunches on landing.
module dino_floor_controller #(
  parameter int unsigned JUMP_V   = 12,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned MAX_FALL = 15,
  parameter int unsigned MAX_Y    = 239,
  parameter int unsigned DINO_X   = 40,
  parameter int unsigned DINO_W   = 20,
  parameter int unsigned CACTUS_W = 12
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       tick,
  input  logic [8:0] floor_x,
  input  logic [7:0] floor_y,
  input  logic       jump_req,
  input  logic       restart,
  input  logic [8:0] cactus_x,
  input  logic [7:0] cactus_h,
  output logic [7:0] dino_y,
  output logic       grounded,
  output logic       land,
  output logic       game_over
);
  typedef enum logic [1:0] {ST_GROUND, ST_RISE, ST_FALL, ST_DEAD} state_e;

  localparam logic [7:0] RESET_Y   = 8'd100;
  localparam logic [7:0] JUMP_V8   = 8'(JUMP_V);
  localparam logic [7:0] GRAV8     = 8'(GRAVITY);
  localparam logic [8:0] GRAV9     = 9'(GRAVITY);
  localparam logic [8:0] MAX_FALL9 = 9'(MAX_FALL);
  localparam logic [8:0] MAX_Y9    = 9'(MAX_Y);
  localparam logic [9:0] DINO_L    = 10'(DINO_X);
  localparam logic [9:0] DINO_R    = 10'(DINO_X + DINO_W - 1);
  localparam logic [9:0] CW_M1     = 10'(CACTUS_W - 1);

  state_e     state_q, state_d;
  logic [7:0] dino_y_q, dino_y_d;
  logic [7:0] vel_q, vel_d;
  logic       pending_q, pending_d;
  logic       land_q, land_d;
  logic       game_over_q, game_over_d;

  // floor_x is carried for the renderer only; the hitbox is anchored at DINO_X
  logic unused_floor_x;
  assign unused_floor_x = ^floor_x;

  // Collision uses the pre-update height and current inputs
  logic [9:0] cactus_r;
  logic [8:0] cactus_top;
  logic       x_hit, y_hit, collide;
  assign cactus_r   = {1'b0, cactus_x} + CW_M1;
  assign cactus_top = {1'b0, floor_y} + {1'b0, cactus_h};
  assign x_hit      = ({1'b0, cactus_x} <= DINO_R) && (cactus_r >= DINO_L);
  assign y_hit      = (cactus_h != 8'd0) && ({1'b0, dino_y_q} < cactus_top);
  assign collide    = x_hit && y_hit;

  logic [8:0]        rise_sum, fall_sum;
  logic [7:0]        rise_y, rise_vel, fall_v;
  logic signed [9:0] fall_y;
  logic              fall_land;

  assign rise_sum  = {1'b0, dino_y_q} + {1'b0, vel_q};
  assign rise_vel  = (vel_q > GRAV8) ? (vel_q - GRAV8) : 8'd0;
  assign fall_sum  = {1'b0, vel_q} + GRAV9;
  assign fall_v    = (fall_sum > MAX_FALL9) ? MAX_FALL9[7:0] : fall_sum[7:0];
  assign fall_y    = $signed({2'b00, dino_y_q}) - $signed({2'b00, fall_v});
  assign fall_land = (fall_y <= $signed({2'b00, floor_y}));

  always_comb begin
    rise_y = (rise_sum > MAX_Y9) ? MAX_Y9[7:0] : rise_sum[7:0];
    if (rise_y < floor_y) rise_y = floor_y;
  end

  always_comb begin
    state_d     = state_q;
    dino_y_d    = dino_y_q;
    vel_d       = vel_q;
    pending_d   = pending_q | jump_req;
    land_d      = 1'b0;
    game_over_d = game_over_q;
    if (tick) begin
      case (state_q)
        ST_GROUND: begin
          if (pending_q) begin
            state_d   = ST_RISE;
            vel_d     = JUMP_V8;
            pending_d = jump_req;
          end else begin
            dino_y_d = floor_y;
          end
        end
        ST_RISE: begin
          dino_y_d = rise_y;
          vel_d    = rise_vel;
          if (rise_vel == 8'd0) state_d = ST_FALL;
`ifndef DINO_JUMP_BUFFER_EN
          pending_d = jump_req;
`endif
        end
        ST_FALL: begin
          vel_d = fall_v;
          if (fall_land) begin
            dino_y_d = floor_y;
            land_d   = 1'b1;
            state_d  = ST_GROUND;
            vel_d    = 8'd0;
`ifdef DINO_JUMP_BUFFER_EN
            if (pending_q) begin
              state_d   = ST_RISE;
              vel_d     = JUMP_V8;
              pending_d = jump_req;
            end
`endif
          end else begin
            dino_y_d = fall_y[7:0];
          end
`ifndef DINO_JUMP_BUFFER_EN
          pending_d = jump_req;
`endif
        end
        default: begin
          if (restart) begin
            state_d     = ST_GROUND;
            dino_y_d    = floor_y;
            vel_d       = 8'd0;
            pending_d   = 1'b0;
            game_over_d = 1'b0;
          end
        end
      endcase
      // Collision wins over landing and launch; height still takes this tick's update
      if (collide && (state_q != ST_DEAD)) begin
        state_d     = ST_DEAD;
        game_over_d = 1'b1;
        land_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_GROUND;
      dino_y_q    <= RESET_Y;
      vel_q       <= 8'd0;
      pending_q   <= 1'b0;
      land_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dino_y_q    <= dino_y_d;
      vel_q       <= vel_d;
      pending_q   <= pending_d;
      land_q      <= land_d;
      game_over_q <= game_over_d;
    end
  end

  assign dino_y    = dino_y_q;
  assign grounded  = (state_q == ST_GROUND);
  assign land      = land_q;
  assign game_over = game_over_q;
endmodule
